// File: rtl/inplace_swap_engine.sv
// In-place swap engine: a small register file whose entries can be
// swapped without temporary storage. A swap runs three add/sub or XOR
// steps, one step per clock, through a single shared ALU.
module inplace_swap_engine #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_idx_a,
    input  logic [ADDR_W-1:0] cmd_idx_b,
    input  logic              cmd_mode,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] idx_a, idx_b;
    logic              mode;

    logic              accept;
    logic [WIDTH-1:0]  op_a, op_b, alu_res;
    logic              alu_we;
    logic [ADDR_W-1:0] alu_dst;

    assign rd_data = mem[rd_addr];
    assign accept  = cmd_valid && (state == IDLE);
    assign op_a    = mem[idx_a];
    assign op_b    = mem[idx_b];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Latch the command operands when a swap is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_a <= '0;
            idx_b <= '0;
            mode  <= 1'b0;
        end else if (accept) begin
            idx_a <= cmd_idx_a;
            idx_b <= cmd_idx_b;
            mode  <= cmd_mode;
        end
    end

    // Next-state, handshake outputs and the shared ALU step selection
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        alu_we     = 1'b0;
        alu_dst    = idx_a;
        alu_res    = '0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    // a self-swap would zero the entry, so skip the steps
                    state_next = (cmd_idx_a == cmd_idx_b) ? DONE : S1;
            end
            S1: begin
                alu_we     = 1'b1;
                alu_res    = mode ? (op_a ^ op_b) : (op_a + op_b);
                state_next = S2;
            end
            S2: begin
                alu_we     = 1'b1;
                alu_dst    = idx_b;
                alu_res    = mode ? (op_a ^ op_b) : (op_a - op_b);
                state_next = S3;
            end
            S3: begin
                alu_we     = 1'b1;
                alu_res    = mode ? (op_a ^ op_b) : (op_a - op_b);
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Register file: external loads only in IDLE, otherwise ALU write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && (state == IDLE)) begin
            mem[wr_addr] <= wr_data;
        end else if (alu_we) begin
            mem[alu_dst] <= alu_res;
        end
    end

endmodule

// File: tb/tb_inplace_swap_engine.sv
// Scoreboard bench for inplace_swap_engine: stimulus pushes the expected
// completion (done cycle and final entry values); a monitor pops and
// checks each time done is presented.
module tb_inplace_swap_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_idx_a;
    logic [2:0] cmd_idx_b;
    logic       cmd_mode;
    logic       busy;
    logic       done;

    logic [2:0] stim_addr;
    logic [2:0] mon_addr;
    logic       mon_active;
    assign rd_addr = mon_active ? mon_addr : stim_addr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] va;
        logic [3:0] vb;
        int         done_cyc;
    } exp_t;
    exp_t sb[$];

    inplace_swap_engine #(.WIDTH(4), .DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_idx_a (cmd_idx_a),
        .cmd_idx_b (cmd_idx_b),
        .cmd_mode  (cmd_mode),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on every done, pop the oldest expectation and compare
    initial begin
        mon_active = 1'b0;
        mon_addr   = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    mon_active = 1'b1;
                    mon_addr   = e.a;
                    #1 chk("result_a", int'(rd_data), int'(e.va));
                    mon_addr   = e.b;
                    #1 chk("result_b", int'(rd_data), int'(e.vb));
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Issue a command; returns 1 time unit after the accept edge
    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic m,
                         input logic [3:0] va, input logic [3:0] vb, input bit push,
                         input bit with_wr, input logic [2:0] wa, input logic [3:0] wd);
        exp_t e;
        @(negedge clk);
        chk("cmd_ready_before_issue", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_idx_a = a; cmd_idx_b = b; cmd_mode = m;
        if (with_wr) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
        e.a = a; e.b = b; e.va = va; e.vb = vb;
        e.done_cyc = cyc + 1 + ((a == b) ? 0 : 3);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !mon_active && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("completion_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_idx_a = '0; cmd_idx_b = '0; cmd_mode = 1'b0;
        stim_addr = '0;
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("post_reset_ready", int'(cmd_ready), 1);
        stim_addr = 3'd4;
        #1 chk("post_reset_mem4", int'(rd_data), 0);

        // add/sub swap 9 <-> 7, cmd_ready low for exactly four cycles
        load(3'd2, 4'd9);
        load(3'd5, 4'd7);
        issue(3'd2, 3'd5, 1'b0, 4'd7, 4'd9, 1'b1, 1'b0, 3'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cmd_ready_low_during_swap", int'(cmd_ready), 0);
        end
        @(negedge clk);
        chk("cmd_ready_back_high", int'(cmd_ready), 1);
        wait_idle();

        // overflow case 15 + 15 -> 14 after S1, both end at 15
        load(3'd1, 4'd15);
        load(3'd6, 4'd15);
        issue(3'd1, 3'd6, 1'b0, 4'd15, 4'd15, 1'b1, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        stim_addr = 3'd1;
        #1 chk("intermediate_after_s1", int'(rd_data), 14);
        wait_idle();

        // XOR swap 1010 <-> 0011
        load(3'd0, 4'b1010);
        load(3'd7, 4'b0011);
        issue(3'd0, 3'd7, 1'b1, 4'b0011, 4'b1010, 1'b1, 1'b0, 3'd0, 4'd0);
        wait_idle();

        // same-index: straight to DONE, entry untouched, busy one cycle
        load(3'd3, 4'd6);
        issue(3'd3, 3'd3, 1'b0, 4'd6, 4'd6, 1'b1, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        chk("same_idx_busy_first", int'(busy), 1);
        @(negedge clk);
        chk("same_idx_busy_second", int'(busy), 0);
        wait_idle();

        // write during S2 is dropped: mem[2]=3, mem[4]=12 swap cleanly
        load(3'd2, 4'd3);
        load(3'd4, 4'd12);
        issue(3'd2, 3'd4, 1'b0, 4'd12, 4'd3, 1'b1, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd1;
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_idle();

        // write and command on one edge: mem[5] <- 11, XOR with mem[6]=15
        issue(3'd5, 3'd6, 1'b1, 4'd15, 4'd11, 1'b1, 1'b1, 3'd5, 4'd11);
        wait_idle();

        // asynchronous reset during S2 aborts and clears everything
        issue(3'd0, 3'd7, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("in_s2_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        for (int i = 0; i < 8; i++) begin
            stim_addr = 3'(i);
            #1 chk("cleared_entry", int'(rd_data), 0);
        end
        @(negedge clk); rst_n = 1'b1;
        #1 chk("ready_after_release", int'(cmd_ready), 1);

        // fresh XOR swap after reset
        load(3'd3, 4'd5);
        load(3'd4, 4'd10);
        issue(3'd3, 3'd4, 1'b1, 4'd10, 4'd5, 1'b1, 1'b0, 3'd0, 4'd0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
